// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arb_pkg                                                |
// | Description : Shared types and default constants for the SDRAM command     |
// |               arbiter: FSM state encoding, requester select encoding and   |
// |               default sizing of the arbiter and its refresh timer.         |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sdram_arb_pkg;

  localparam int c_default_aw             = 24;
  localparam int c_default_dw             = 16;
  localparam int c_default_refresh_cycles = 420;  // 7.5 us at 56 MHz
  localparam int c_default_max_defer      = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CPU  = 3'd1,
    ST_DMA  = 3'd2,
    ST_REF  = 3'd3,
    ST_ACK  = 3'd4
  } arb_state_t;

  // Which requester owns the command currently in flight / being acknowledged.
  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_DMA = 1'b1
  } port_sel_t;

endpackage
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_refresh_timer                                          |
// | Description : Free-running 0..REFRESH_CYCLES-1 wrap counter. Each wrap     |
// |               raises a single (non-queued) refresh request; a wrap while   |
// |               the request is still pending sets a sticky overrun flag.     |
// | Ports       : clock56     - system clock, rising edge                      |
// |               reset       - asynchronous, active-high                      |
// |               clr         - refresh completed (memDone while in REF)       |
// |               ref_req     - refresh request pending                        |
// |               ref_overrun - sticky overrun flag, cleared only by reset     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = c_default_refresh_cycles
) (
  input  logic clock56,
  input  logic reset,
  input  logic clr,
  output logic ref_req,
  output logic ref_overrun
);

  localparam int c_cw = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(REFRESH_CYCLES - 1);

  logic [c_cw-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            ovr_q, ovr_d;
  logic            w_wrap;

  always_comb begin
    w_wrap = (cnt_q == c_last);
    cnt_d  = w_wrap ? '0 : cnt_q + 1'b1;
    req_d  = req_q;
    if (clr) req_d = 1'b0;
    // A new interval elapsing wins over a completion in the same cycle.
    if (w_wrap) req_d = 1'b1;
    // The refresh finishing in this very cycle is not an overrun.
    ovr_d = ovr_q | (w_wrap & req_q & ~clr);
  end

  always_ff @(posedge clock56 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      req_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
      ovr_q <= ovr_d;
    end
  end

  assign ref_req     = req_q;
  assign ref_overrun = ovr_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_arbiter                                                |
// | Description : Shares the single SDRAM command port between the CPU, a DMA  |
// |               loader and periodic auto-refresh. One command at a time;     |
// |               read data and a one-cycle Ack go back to the winner.         |
// | Ports       : clock56/reset        - clock, async active-high reset        |
// |               ready                - SDRAM init done; no grants while low  |
// |               cpuRd/cpuWr/cpuA/cpuD/cpuQ/cpuAck - CPU request port         |
// |               dmaRd/dmaWr/dmaA/dmaD/dmaQ/dmaAck - DMA loader port          |
// |               memRd/memWr/memRef/memA/memD      - command to SDRAM core    |
// |               memQ/memDone         - read data / completion pulse          |
// |               refOverrun           - sticky refresh overrun flag           |
// | Config      : SDRAM_ARB_DMA_RD_EN - enables DMA reads; when undefined the  |
// |               DMA port is write-only and dmaQ is tied to zero.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW             = c_default_aw,
  parameter int DW             = c_default_dw,
  parameter int REFRESH_CYCLES = c_default_refresh_cycles,
  parameter int MAX_DEFER      = c_default_max_defer
) (
  input  logic          clock56,
  input  logic          reset,
  input  logic          ready,
  input  logic          cpuRd,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [DW-1:0] cpuD,
  output logic [DW-1:0] cpuQ,
  output logic          cpuAck,
  input  logic          dmaRd,
  input  logic          dmaWr,
  input  logic [AW-1:0] dmaA,
  input  logic [DW-1:0] dmaD,
  output logic [DW-1:0] dmaQ,
  output logic          dmaAck,
  output logic          memRd,
  output logic          memWr,
  output logic          memRef,
  output logic [AW-1:0] memA,
  output logic [DW-1:0] memD,
  input  logic [DW-1:0] memQ,
  input  logic          memDone,
  output logic          refOverrun
);

  localparam int c_dfw = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [c_dfw-1:0] c_defer_max = c_dfw'(MAX_DEFER);

  arb_state_t      state_q, state_d;
  port_sel_t       sel_q, sel_d;
  logic            wr_q, wr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            mem_ref_q, mem_ref_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [DW-1:0]   mem_d_q, mem_d_d;
  logic [DW-1:0]   cpu_q_q, cpu_q_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            dma_ack_q, dma_ack_d;
  logic [c_dfw-1:0] defer_q, defer_d;

  logic w_ref_req;
  logic w_ref_done;
  logic w_dma_rd;
  logic w_cpu_req;
  logic w_dma_req;

  assign w_ref_done = (state_q == ST_REF) && memDone;

  sdram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clock56    (clock56),
    .reset      (reset),
    .clr        (w_ref_done),
    .ref_req    (w_ref_req),
    .ref_overrun(refOverrun)
  );

`ifdef SDRAM_ARB_DMA_RD_EN
  logic [DW-1:0] dma_q_q, dma_q_d;

  assign w_dma_rd = dmaRd;

  always_comb begin
    dma_q_d = dma_q_q;
    if ((state_q == ST_DMA) && memDone && !wr_q) dma_q_d = memQ;
  end

  always_ff @(posedge clock56 or posedge reset) begin
    if (reset) dma_q_q <= '0;
    else       dma_q_q <= dma_q_d;
  end

  assign dmaQ = dma_q_q;
`else
  // Write-only DMA port: reads are never granted and the input is dropped.
  logic w_unused_dma_rd;
  assign w_unused_dma_rd = dmaRd;
  assign w_dma_rd        = 1'b0;
  assign dmaQ            = '0;
`endif

  assign w_cpu_req = cpuRd | cpuWr;
  assign w_dma_req = dmaWr | w_dma_rd;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    cpu_q_d   = cpu_q_q;
    defer_d   = defer_q;
    // Strobes and Acks are single-cycle: they default low every cycle.
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    mem_ref_d = 1'b0;
    cpu_ack_d = 1'b0;
    dma_ack_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          if (w_ref_req && (defer_q == c_defer_max)) begin
            state_d   = ST_REF;
            mem_ref_d = 1'b1;
          end else if (w_cpu_req) begin
            state_d  = ST_CPU;
            sel_d    = SEL_CPU;
            wr_d     = cpuWr;        // write wins if both are raised
            mem_wr_d = cpuWr;
            mem_rd_d = ~cpuWr;
            mem_a_d  = cpuA;
            mem_d_d  = cpuD;
            // Reaching here with a pending refresh implies defer_q < max,
            // so the increment cannot overflow past MAX_DEFER.
            if (w_ref_req) defer_d = defer_q + 1'b1;
          end else if (w_ref_req) begin
            state_d   = ST_REF;
            mem_ref_d = 1'b1;
          end else if (w_dma_req) begin
            state_d  = ST_DMA;
            sel_d    = SEL_DMA;
            wr_d     = dmaWr;
            mem_wr_d = dmaWr;
            mem_rd_d = ~dmaWr;
            mem_a_d  = dmaA;
            mem_d_d  = dmaD;
          end
        end
      end

      ST_CPU, ST_DMA: begin
        if (memDone) begin
          state_d   = ST_ACK;
          cpu_ack_d = (sel_q == SEL_CPU);
          dma_ack_d = (sel_q == SEL_DMA);
          if (!wr_q && (sel_q == SEL_CPU)) cpu_q_d = memQ;
        end
      end

      ST_REF: begin
        if (memDone) begin
          state_d = ST_IDLE;
          defer_d = '0;
        end
      end

      ST_ACK:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock56 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_CPU;
      wr_q      <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_ref_q <= 1'b0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      cpu_q_q   <= '0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      defer_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      mem_ref_q <= mem_ref_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
      cpu_q_q   <= cpu_q_d;
      cpu_ack_q <= cpu_ack_d;
      dma_ack_q <= dma_ack_d;
      defer_q   <= defer_d;
    end
  end

  assign memRd  = mem_rd_q;
  assign memWr  = mem_wr_q;
  assign memRef = mem_ref_q;
  assign memA   = mem_a_q;
  assign memD   = mem_d_q;
  assign cpuQ   = cpu_q_q;
  assign cpuAck = cpu_ack_q;
  assign dmaAck = dma_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_arbiter                                             |
// | Description : Directed self-checking bench for sdram_arbiter with a simple |
// |               SDRAM core responder (fixed latency, optional withholding).  |
// |               Built with SDRAM_ARB_DMA_RD_EN undefined (write-only DMA).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdram_arbiter;

  localparam int AW             = 24;
  localparam int DW             = 16;
  localparam int REFRESH_CYCLES = 420;
  localparam int MAX_DEFER      = 2;
  localparam int LAT            = 2;   // core pulses memDone LAT cycles after the strobe cycle

  localparam int EV_RD   = 1;
  localparam int EV_WR   = 2;
  localparam int EV_REF  = 3;
  localparam int EV_CACK = 4;
  localparam int EV_DACK = 5;

  logic          clock56 = 1'b0;
  logic          reset   = 1'b1;
  logic          ready   = 1'b1;
  logic          cpuRd   = 1'b0;
  logic          cpuWr   = 1'b0;
  logic [AW-1:0] cpuA    = '0;
  logic [DW-1:0] cpuD    = '0;
  logic [DW-1:0] cpuQ;
  logic          cpuAck;
  logic          dmaRd   = 1'b0;
  logic          dmaWr   = 1'b0;
  logic [AW-1:0] dmaA    = '0;
  logic [DW-1:0] dmaD    = '0;
  logic [DW-1:0] dmaQ;
  logic          dmaAck;
  logic          memRd;
  logic          memWr;
  logic          memRef;
  logic [AW-1:0] memA;
  logic [DW-1:0] memD;
  logic [DW-1:0] memQ    = '0;
  logic          memDone = 1'b0;
  logic          refOverrun;

  sdram_arbiter #(
    .AW(AW), .DW(DW), .REFRESH_CYCLES(REFRESH_CYCLES), .MAX_DEFER(MAX_DEFER)
  ) dut (
    .clock56(clock56), .reset(reset), .ready(ready),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
    .dmaRd(dmaRd), .dmaWr(dmaWr), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
    .memRd(memRd), .memWr(memWr), .memRef(memRef), .memA(memA), .memD(memD),
    .memQ(memQ), .memDone(memDone), .refOverrun(refOverrun)
  );

  always #5 clock56 = ~clock56;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            n_rd = 0, n_wr = 0, n_ref = 0, n_cack = 0, n_dack = 0;
  int            strobe_cyc = 0, cack_cyc = 0, dack_cyc = 0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;
  int            ev_q[$];
  bit            withhold = 1'b0;
  logic [DW-1:0] resp_q = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock56);
    #1;
  endtask

  function automatic logic [31:0] pack_ev();
    logic [31:0] v = '0;
    foreach (ev_q[i]) v = (v << 4) | 32'(ev_q[i]);
    return v;
  endfunction

  // Monitor: cycle index, strobe/ack counts and event order, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock56);
      cyc++;
      if (memRd)  begin n_rd++;  ev_q.push_back(EV_RD);  strobe_cyc = cyc; last_a = memA; last_d = memD; end
      if (memWr)  begin n_wr++;  ev_q.push_back(EV_WR);  strobe_cyc = cyc; last_a = memA; last_d = memD; end
      if (memRef) begin n_ref++; ev_q.push_back(EV_REF); strobe_cyc = cyc; end
      if (cpuAck) begin n_cack++; ev_q.push_back(EV_CACK); cack_cyc = cyc; end
      if (dmaAck) begin n_dack++; ev_q.push_back(EV_DACK); dack_cyc = cyc; end
    end
  end

  // SDRAM core model: one-cycle memDone LAT cycles after any strobe.
  initial begin
    forever begin
      @(negedge clock56);
      if ((memRd || memWr || memRef) && !withhold) begin
        repeat (LAT) @(negedge clock56);
        memQ    = resp_q;
        memDone = 1'b1;
        @(negedge clock56);
        memDone = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic rdy);
    reset    = 1'b1;
    cpuRd    = 1'b0; cpuWr = 1'b0;
    dmaRd    = 1'b0; dmaWr = 1'b0;
    ready    = rdy;
    withhold = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    ev_q.delete();
  endtask

  task automatic cpu_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic ok);
    cpuA = a; cpuD = d; cpuWr = wr; cpuRd = ~wr;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (cpuAck) ok = 1'b1;
    end
    cpuRd = 1'b0; cpuWr = 1'b0;
  endtask

  task automatic dma_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic ok);
    dmaA = a; dmaD = d; dmaWr = wr; dmaRd = ~wr;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (dmaAck) ok = 1'b1;
    end
    dmaRd = 1'b0; dmaWr = 1'b0;
  endtask

  // Held CPU read stream released together with ready while a refresh is pending.
  task automatic defer_run(output logic [31:0] pk);
    int acks = 0;
    ev_q.delete();
    cpuA  = 24'h000400;
    cpuRd = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 300 && acks < 3; i++) begin
      step();
      if (cpuAck) acks++;
    end
    cpuRd = 1'b0;
    repeat (4) step();
    pk = pack_ev();
  endtask

  initial begin
    logic        ok, ok2;
    int          req_cyc, b_rd, b_wr, b_ref, b_cack, b_dack;
    logic [31:0] pk;

    // ---------------- reset values
    do_reset(1'b1);
    chk("rst_memRd",      32'(memRd),      32'h0);
    chk("rst_memWr",      32'(memWr),      32'h0);
    chk("rst_memRef",     32'(memRef),     32'h0);
    chk("rst_acks",       32'({cpuAck, dmaAck}), 32'h0);
    chk("rst_refOverrun", 32'(refOverrun), 32'h0);
    chk("rst_cpuQ",       32'(cpuQ),       32'h0);
    chk("rst_memA",       32'(memA),       32'h0);
    chk("rst_memD",       32'(memD),       32'h0);

    // ---------------- CPU read then write
    resp_q = 16'h55AA;
    b_rd = n_rd; b_cack = n_cack; req_cyc = cyc;
    cpu_req(1'b0, 24'h00C000, 16'h0000, ok);
    chk("rd_ack",        32'(ok), 32'h1);
    chk("rd_strobes",    n_rd - b_rd, 1);
    chk("rd_memA",       32'(last_a), 32'h00C000);
    chk("rd_strobe_lat", strobe_cyc - req_cyc, 1);
    chk("rd_ack_lat",    cack_cyc - strobe_cyc, LAT + 1);
    chk("rd_cpuQ",       32'(cpuQ), 32'h55AA);
    chk("rd_ack_cnt",    n_cack - b_cack, 1);

    resp_q = 16'h1111;
    b_wr = n_wr;
    cpu_req(1'b1, 24'h00C002, 16'hBEEF, ok);
    chk("wr_ack",     32'(ok), 32'h1);
    chk("wr_strobes", n_wr - b_wr, 1);
    chk("wr_memD",    32'(last_d), 32'hBEEF);
    chk("wr_cpuQ_kept", 32'(cpuQ), 32'h55AA);

    // ---------------- CPU and DMA in the same cycle: CPU first
    do_reset(1'b1);
    fork
      cpu_req(1'b0, 24'h000010, 16'h0000, ok);
      dma_req(1'b1, 24'h000020, 16'hA5A5, ok2);
    join
    repeat (5) step();
    chk("both_cpu_ack", 32'(ok), 32'h1);
    chk("both_dma_ack", 32'(ok2), 32'h1);
    chk("both_order",   pack_ev(), 32'h1425);  // RD, cpuAck, WR, dmaAck
    chk("both_dma_gap", strobe_cyc - cack_cyc, 2);

    // ---------------- DMA reads ignored in the write-only build
    do_reset(1'b1);
    b_rd = n_rd; b_dack = n_dack;
    dmaA = 24'h000100; dmaRd = 1'b1;
    repeat (20) step();
    dmaRd = 1'b0;
    chk("dmard_no_memRd", n_rd - b_rd, 0);
    chk("dmard_no_ack",   n_dack - b_dack, 0);
    dma_req(1'b1, 24'h000100, 16'h1234, ok);
    chk("dmawr_ack",  32'(ok), 32'h1);
    chk("dmawr_memD", 32'(last_d), 32'h1234);
    chk("dmawr_memA", 32'(last_a), 32'h000100);
    chk("dmaQ_zero",  32'(dmaQ), 32'h0);

    // ---------------- refresh deferral: two CPU grants, then REF, then CPU
    do_reset(1'b0);
    repeat (REFRESH_CYCLES + 10) step();
    b_ref = n_ref;
    defer_run(pk);
    chk("defer_order1", pk, 32'h1414314);
    chk("defer_ref_cnt", n_ref - b_ref, 1);
    // Defer count must be back at 0: the next pending refresh bypasses twice again.
    ready = 1'b0;
    repeat (REFRESH_CYCLES + 30) step();
    defer_run(pk);
    chk("defer_order2", pk, 32'h1414314);

    // ---------------- refresh overrun while memDone is withheld
    do_reset(1'b1);
    withhold = 1'b1;
    b_cack = n_cack;
    cpuA = 24'h000200; cpuRd = 1'b1;
    repeat (REFRESH_CYCLES + 180) step();
    chk("ovr_single_pending", 32'(refOverrun), 32'h0);
    chk("ovr_no_ack",         n_cack - b_cack, 0);
    repeat (REFRESH_CYCLES / 2 + 90) step();
    chk("ovr_set",    32'(refOverrun), 32'h1);
    repeat (100) step();
    chk("ovr_sticky", 32'(refOverrun), 32'h1);
    cpuRd = 1'b0;
    do_reset(1'b1);
    chk("ovr_cleared", 32'(refOverrun), 32'h0);

    // ---------------- reset one cycle after a memWr strobe
    resp_q = 16'h3C3C;
    cpu_req(1'b0, 24'h000300, 16'h0000, ok);
    chk("pre_cpuQ", 32'(cpuQ), 32'h3C3C);
    withhold = 1'b1;
    b_wr = n_wr;
    cpuA = 24'h123456; cpuD = 16'hBEEF; cpuWr = 1'b1;
    for (int i = 0; i < 20 && n_wr == b_wr; i++) step();
    chk("mid_wr_strobe", n_wr - b_wr, 1);
    step();
    reset = 1'b1;
    cpuWr = 1'b0;
    b_cack = n_cack;
    step();
    chk("mid_memWr", 32'(memWr), 32'h0);
    chk("mid_memA",  32'(memA),  32'h0);
    chk("mid_memD",  32'(memD),  32'h0);
    chk("mid_cpuQ",  32'(cpuQ),  32'h0);
    step();
    reset = 1'b0;
    withhold = 1'b0;
    repeat (10) step();
    chk("mid_no_ack", n_cack - b_cack, 0);
    resp_q = 16'h0F0F;
    cpu_req(1'b0, 24'h00ABCD, 16'h0000, ok);
    chk("post_ack",  32'(ok), 32'h1);
    chk("post_cpuQ", 32'(cpuQ), 32'h0F0F);
    chk("post_memA", 32'(last_a), 32'h00ABCD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Schedules the single SDRAM command port between the Z80-side memory request (CPU), a DMA loader port that fills ROM/DivMMC images before and during emulation, and periodic auto-refresh. Sits between the memory-decode logic and the `sdram` core on the `clock56` domain. Issues one command at a time, waits for completion, and returns read data and a one-cycle acknowledge to the winning requester.

## Interface
- `AW`, 24: SDRAM word address width.
- `DW`, 16: data width.
- `REFRESH_CYCLES`, 420: `clock56` cycles between refresh requests (7.5 µs).
- `MAX_DEFER`, 2: CPU grants allowed to bypass a pending refresh.

Ports:
- `clock56` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ready` in 1: SDRAM init complete; no grants while low.
- `cpuRd`, `cpuWr` in 1: CPU level requests, held until `cpuAck`.
- `cpuA` in AW; `cpuD` in DW; `cpuQ` out DW; `cpuAck` out 1.
- `dmaRd`, `dmaWr` in 1; `dmaA` in AW; `dmaD` in DW; `dmaQ` out DW; `dmaAck` out 1.
- `memRd`, `memWr`, `memRef` out 1: single-cycle command strobes to the core.
- `memA` out AW; `memD` out DW; `memQ` in DW; `memDone` in 1: one-cycle completion pulse.
- `refOverrun` out 1: sticky; a refresh interval elapsed while the previous refresh was still pending.

## Operation
- States: IDLE, CPU, DMA, REF, ACK.
- IDLE: if `ready` is low, stay in IDLE. Otherwise priority is:
  1. REF if the refresh request is pending and the defer count equals MAX_DEFER.
  2. CPU if `cpuRd` or `cpuWr` is high.
  3. REF if the refresh request is pending.
  4. DMA if `dmaRd` or `dmaWr` is high.
- Grant: latch address, data and direction into `memA`/`memD`. Pulse exactly one of `memRd`, `memWr` or `memRef` in the first cycle of the new state. If Rd and Wr are both high, the write is issued.
- CPU grant while the refresh request is pending: defer count +1 (saturates at MAX_DEFER).
- CPU/DMA state: wait for `memDone`. On `memDone`, a read latches `memQ` into `cpuQ`/`dmaQ`. Then go to ACK.
- REF state: wait for `memDone`, then clear the refresh request and the defer count, then go to IDLE (no ACK).
- ACK: the granted port's Ack is high for exactly one cycle, then IDLE. The requester must hold its request low in the cycle after Ack, otherwise the same request is re-issued.
- Refresh timer: counts 0..REFRESH_CYCLES-1 and wraps. On wrap it sets the refresh request. A wrap while the request is already set sets `refOverrun`; the request stays single, not queued.
- `cpuQ`/`dmaQ` hold their value until the next read for that port; writes do not alter them.
- `memA`/`memD` hold between commands.
- `memDone` in IDLE or ACK is ignored.

## Timing
- Reset values: `memRd`, `memWr`, `memRef`, `cpuAck`, `dmaAck`, `refOverrun` = 0; `cpuQ`, `dmaQ`, `memA`, `memD` = 0; state IDLE; timer 0; refresh request 0; defer count 0.
- Request sampled at edge k. Strobe is high in cycle k+1. `memDone` arrives in cycle m. Ack and Q are valid in cycle m+1. Minimum request-to-Ack is 2 cycles plus core latency.
- Back-to-back grants: the next grant is sampled at the earliest in the cycle after ACK.
- Reset mid-command: all state returns to reset values immediately. The in-flight command is abandoned and no Ack is generated.
- `ready` falling mid-command: the current command completes normally, and no further grants are issued.

## Configuration
- `SDRAM_ARB_DMA_RD_EN` defined: the DMA port supports reads, and `dmaQ` is driven from `memQ`.
- `SDRAM_ARB_DMA_RD_EN` undefined: `dmaRd` is ignored (never granted), `dmaQ` is tied to 0, and only DMA writes are arbitrated.

## Structure
- Package `sdram_arb_pkg`:
  - state enum;
  - default constants for AW, DW, REFRESH_CYCLES, MAX_DEFER;
  - port-select encoding.
- Sub-module `sdram_refresh_timer`: wrap counter plus request/overrun flags, with clear-on-`memDone`-in-REF input.
- Arbiter FSM and datapath latches live in the top module.

## Test plan
- CPU read `cpuA`=0x00C000, `memQ`=0x55AA on the `memDone` pulse -> `memRd` pulses once with `memA`=0x00C000; `cpuAck` 1 cycle later; `cpuQ`=0x55AA.
- CPU and DMA requests raised in the same cycle -> CPU granted first; DMA strobe issued only after `cpuAck` plus 1 cycle; exactly one Ack per port.
- Refresh pending with continuous CPU requests, MAX_DEFER=2 -> two CPU grants, then `memRef` before the third CPU grant; defer count returns to 0.
- `memDone` withheld for more than REFRESH_CYCLES while a refresh is already pending -> `refOverrun`=1, held until `reset`.
- `reset` asserted 1 cycle after a `memWr` strobe -> no Ack, all outputs at reset values next cycle; after release, the first request is serviced normally.
- With `SDRAM_ARB_DMA_RD_EN` undefined, `dmaRd`=1 -> no `memRd`, `dmaAck` stays 0; `dmaWr` with `dmaD`=0x1234 -> `memWr` with `memD`=0x1234.
